// File: rtl/tmc_uart_pkg.sv
// tmc_uart_pkg: shared UART types and constants for the RS232 serializer and
// deserializer: FSM state enum, default clock/baud and baud-divisor rounding.
package tmc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ_HZ = 50000000;
  localparam int unsigned DEF_BAUD_RATE   = 115200;

  // Nearest-integer clocks per bit: round(clk_hz / baud).
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, with a
// selectable reset value so the output starts in the safe (inactive) state.
module sync_2ff #(
  parameter logic P_RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= P_RESET_VAL;
      sync_q <= P_RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rs232_ser.sv
// rs232_ser: RS232 transmit serializer. Pops bytes from a standard-mode
// (non-show-ahead) TX FIFO while the host allows it (cts_n low) and sends
// them LSB first as 8N1 frames on tx.
// Build option: define RS232_SER_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 frames).
//
// FIFO handshake: tx_fifo_empty == 0 acts as "valid"; tx_fifo_rd_en is a
// one-cycle "take" pulse issued only from IDLE while valid and cts_s == 0.
// The FIFO returns the byte on tx_fifo_data in the cycle after the pulse,
// which is the first START cycle, so the byte is captured there.
module rs232_ser
  import tmc_uart_pkg::*;
#(
  parameter int unsigned P_CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned P_BAUD_RATE   = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_fifo_data,
  input  logic       tx_fifo_empty,
  output logic       tx_fifo_rd_en,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned P_BAUD_DIV = baud_div(P_CLK_FREQ_HZ, P_BAUD_RATE);
  localparam int unsigned BCW        = $clog2(P_BAUD_DIV);
  localparam logic [BCW-1:0] BAUD_LOAD = BCW'(P_BAUD_DIV - 1);

  uart_state_e    state_q, state_d;
  logic [BCW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           rd_en_q, rd_en_d;
  logic           busy_q, busy_d;
  logic           cts_s;
  logic           baud_expired;
  logic           first_start_cycle;
`ifdef RS232_SER_PARITY_EN
  logic           parity_q, parity_d;
`endif

  sync_2ff #(
    .P_RESET_VAL(1'b1)
  ) u_cts_sync (
    .clk (clk),
    .rst (rst),
    .d   (cts_n),
    .q   (cts_s)
  );

  assign baud_expired      = (baud_cnt_q == '0);
  assign first_start_cycle = (state_q == START) && (baud_cnt_q == BAUD_LOAD);

  // Next-state, bit timing and line-level decisions for the frame FSM.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
`ifdef RS232_SER_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q inside {START, DATA, PARITY, STOP}) begin
      baud_cnt_d = baud_expired ? BAUD_LOAD : (baud_cnt_q - BCW'(1));
    end
    case (state_q)
      IDLE: begin
        if (!cts_s && !tx_fifo_empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        baud_cnt_d = BAUD_LOAD;
        tx_d       = 1'b0;
        state_d    = START;
      end
      START: begin
        if (first_start_cycle) begin
          shift_d = tx_fifo_data;
`ifdef RS232_SER_PARITY_EN
          parity_d = ^tx_fifo_data;
`endif
        end
        if (baud_expired) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_expired) begin
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else begin
`ifdef RS232_SER_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RS232_SER_PARITY_EN
      PARITY: begin
        if (baud_expired) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_expired) begin
          busy_d     = 1'b0;
          baud_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM registers; reset parks the line high and drops any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RS232_SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
`ifdef RS232_SER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign tx_fifo_rd_en = rd_en_q;
  assign busy          = busy_q;

endmodule
